// File: rtl/feedback_pkg.sv
// Shared types and constants for the feedback beeper: FSM states, event
// patterns (priority encoded by value) and the error beep count.
package feedback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // A numerically larger pattern wins when events coincide or pre-empt.
  typedef enum logic [1:0] {
    PAT_NONE = 2'd0,
    PAT_KEY  = 2'd1,
    PAT_OK   = 2'd2,
    PAT_ERR  = 2'd3
  } pattern_t;

  localparam logic [1:0] ERR_BEEPS = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/feedback_beeper_if.sv
// Event pulses from the lock controller and the buzzer/LED drive back to the board.
interface feedback_beeper_if;
  logic key_pulse;
  logic ok_pulse;
  logic err_pulse;
  logic beep_out;
  logic led_ok;
  logic led_err;
  logic busy;

  modport master (
    output key_pulse, ok_pulse, err_pulse,
    input  beep_out, led_ok, led_err, busy
  );

  modport slave (
    input  key_pulse, ok_pulse, err_pulse,
    output beep_out, led_ok, led_err, busy
  );
endinterface

// File: rtl/feedback_beeper_unit_tick.sv
// Time-unit prescaler: one-cycle tick every TICK_DIV clocks, restartable by a
// synchronous clear so a new phase always starts on a full unit.
module unit_tick #(
  parameter int TICK_DIV = 125000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt_q;

  assign tick = (cnt_q == PW'(TICK_DIV - 1)) && !clr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/feedback_beeper.sv
// Turns single-cycle lock events into audible/visible patterns on the buzzer and LEDs.
// Define BEEP_TONE_EN to drive a passive piezo with a TONE_DIV square wave during beeps.
module feedback_beeper
  import feedback_pkg::*;
#(
  parameter int TICK_DIV = 125000,
  parameter int SHORT_U  = 60,
  parameter int LONG_U   = 500,
  parameter int GAP_U    = 80,
  parameter int TONE_DIV = 31250
) (
  input  logic              clk,
  input  logic              rst_n,
  feedback_beeper_if.slave  bus
);

  localparam int UW = $clog2(max3(SHORT_U, LONG_U, GAP_U) + 1);

  if (TICK_DIV < 1 || SHORT_U < 1 || LONG_U < 1 || GAP_U < 1 || TONE_DIV < 1) begin : g_param_check
    $error("feedback_beeper: timing parameters must be 1 or greater");
  end

  state_t        state_q, state_d;
  pattern_t      pattern_q, pattern_d;
  pattern_t      evt;
  logic [1:0]    beeps_q, beeps_d;
  logic [UW-1:0] unit_q, unit_d;
  logic          start;
  logic          tick;
  logic          beep_d;

  logic beep_q, led_ok_q, led_err_q, busy_q;

  function automatic logic [UW-1:0] on_len(input pattern_t p);
    return (p == PAT_OK) ? UW'(LONG_U) : UW'(SHORT_U);
  endfunction

  // Highest-priority event this cycle; pre-empts only a strictly weaker pattern.
  always_comb begin
    if (bus.err_pulse)     evt = PAT_ERR;
    else if (bus.ok_pulse) evt = PAT_OK;
    else if (bus.key_pulse) evt = PAT_KEY;
    else                   evt = PAT_NONE;
  end

  assign start = (evt > pattern_q);

  unit_tick #(.TICK_DIV(TICK_DIV)) u_unit_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start || (state_q == ST_IDLE)),
    .tick  (tick)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d   = state_q;
    pattern_d = pattern_q;
    beeps_d   = beeps_q;
    unit_d    = unit_q;

    if (start) begin
      state_d   = ST_ON;
      pattern_d = evt;
      beeps_d   = (evt == PAT_ERR) ? ERR_BEEPS : 2'd1;
      unit_d    = on_len(evt);
    end else if (tick && (state_q != ST_IDLE)) begin
      if (unit_q > UW'(1)) begin
        unit_d = unit_q - UW'(1);
      end else begin
        case (state_q)
          ST_ON: begin
            if (beeps_q > 2'd1) begin
              state_d = ST_GAP;
              beeps_d = beeps_q - 2'd1;
              unit_d  = UW'(GAP_U);
            end else begin
              state_d   = ST_IDLE;
              pattern_d = PAT_NONE;
              beeps_d   = 2'd0;
              unit_d    = '0;
            end
          end
          ST_GAP: begin
            state_d = ST_ON;
            unit_d  = on_len(pattern_q);
          end
          default: begin
            state_d   = ST_IDLE;
            pattern_d = PAT_NONE;
            beeps_d   = 2'd0;
            unit_d    = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pattern_q <= PAT_NONE;
      beeps_q   <= 2'd0;
      unit_q    <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      beeps_q   <= beeps_d;
      unit_q    <= unit_d;
    end
  end

`ifdef BEEP_TONE_EN
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  logic [TW-1:0] tone_cnt_q;
  logic          tone_q;
  logic          enter_on;

  // The tone restarts low on every ON entry, including a pre-empting restart.
  assign enter_on = (state_d == ST_ON) && (start || (state_q != ST_ON));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (enter_on) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (state_q == ST_ON) begin
      if (tone_cnt_q == TW'(TONE_DIV - 1)) begin
        tone_cnt_q <= '0;
        tone_q     <= ~tone_q;
      end else begin
        tone_cnt_q <= tone_cnt_q + TW'(1);
      end
    end
  end

  assign beep_d = (state_q == ST_ON) && tone_q;
`else
  assign beep_d = (state_q == ST_ON);
`endif

  // Registered outputs follow the state by one clock; reset silences them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep_q    <= 1'b0;
      led_ok_q  <= 1'b0;
      led_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      beep_q    <= beep_d;
      led_ok_q  <= (pattern_q == PAT_OK)  && (state_q != ST_IDLE);
      led_err_q <= (pattern_q == PAT_ERR) && (state_q != ST_IDLE);
      busy_q    <= (state_q != ST_IDLE);
    end
  end

  assign bus.beep_out = beep_q;
  assign bus.led_ok   = led_ok_q;
  assign bus.led_err  = led_err_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_feedback_beeper.sv
// Scoreboard bench for feedback_beeper: each scenario queues the expected
// per-cycle {beep_out, led_ok, led_err, busy} trace and compares it cycle by cycle.
module tb_feedback_beeper;

  localparam int TICK_DIV = 4;
  localparam int SHORT_U  = 2;
  localparam int LONG_U   = 5;
  localparam int GAP_U    = 2;

  localparam int SHORT_C = SHORT_U * TICK_DIV;
  localparam int LONG_C  = LONG_U * TICK_DIV;
  localparam int GAP_C   = GAP_U * TICK_DIV;

  // Output vector encodings: {beep_out, led_ok, led_err, busy}
  localparam logic [3:0] O_IDLE    = 4'b0000;
  localparam logic [3:0] O_KEY     = 4'b1001;
  localparam logic [3:0] O_OK      = 4'b1101;
  localparam logic [3:0] O_ERR_ON  = 4'b1011;
  localparam logic [3:0] O_ERR_GAP = 4'b0011;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  feedback_beeper_if bus ();

  feedback_beeper #(
    .TICK_DIV (TICK_DIV),
    .SHORT_U  (SHORT_U),
    .LONG_U   (LONG_U),
    .GAP_U    (GAP_U),
    .TONE_DIV (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [3:0] exp_q[$];
  int         checks    = 0;
  int         failures  = 0;
  int         sample_no = 0;
  string      scen      = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.beep_out, bus.led_ok, bus.led_err, bus.busy};
  endfunction

  task automatic push(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic push_err();
    push(O_ERR_ON, SHORT_C);
    push(O_ERR_GAP, GAP_C);
    push(O_ERR_ON, SHORT_C);
    push(O_ERR_GAP, GAP_C);
    push(O_ERR_ON, SHORT_C);
  endtask

  task automatic pop_check();
    logic [3:0] e;
    sample_no++;
    check($sformatf("%s_sb_nonempty_s%0d", scen, sample_no), 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_s%0d", scen, sample_no), 32'(outs()), 32'(e));
    end
  endtask

  task automatic start_scen(input string name);
    scen      = name;
    sample_no = 0;
  endtask

  // One clock: drive pulses, let the edge sample them, then compare outputs.
  task automatic cycle(input logic k, input logic o, input logic e);
    bus.key_pulse = k;
    bus.ok_pulse  = o;
    bus.err_pulse = e;
    @(posedge clk);
    #1;
    bus.key_pulse = 1'b0;
    bus.ok_pulse  = 1'b0;
    bus.err_pulse = 1'b0;
    pop_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.key_pulse = 1'b0;
    bus.ok_pulse  = 1'b0;
    bus.err_pulse = 1'b0;

    #1 rst_n = 1'b0;
    #11;
    start_scen("reset");
    push(O_IDLE, 1);
    pop_check();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Key at cycle 10: high for cycles 11..18.
    start_scen("key");
    push(O_IDLE, 10);
    push(O_KEY, SHORT_C);
    push(O_IDLE, 3);
    idle(9);
    cycle(1'b1, 1'b0, 1'b0);
    idle(11);

    start_scen("ok");
    push(O_IDLE, 1);
    push(O_OK, LONG_C);
    push(O_IDLE, 3);
    cycle(1'b0, 1'b1, 1'b0);
    idle(LONG_C + 3);

    start_scen("err");
    push(O_IDLE, 1);
    push_err();
    push(O_IDLE, 3);
    cycle(1'b0, 1'b0, 1'b1);
    idle(3 * SHORT_C + 2 * GAP_C + 3);

    // Key then err three cycles later; later key and ok are dropped.
    start_scen("key_err_preempt");
    push(O_IDLE, 1);
    push(O_KEY, 3);
    push_err();
    push(O_IDLE, 3);
    cycle(1'b1, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1);
    idle(10);
    cycle(1'b1, 1'b0, 1'b0);
    idle(4);
    cycle(1'b0, 1'b1, 1'b0);
    idle(27);

    start_scen("key_ok_preempt");
    push(O_IDLE, 1);
    push(O_KEY, 2);
    push(O_OK, LONG_C);
    push(O_IDLE, 3);
    cycle(1'b1, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0);
    idle(LONG_C + 3);

    start_scen("all_three");
    push(O_IDLE, 1);
    push_err();
    push(O_IDLE, 3);
    cycle(1'b1, 1'b1, 1'b1);
    idle(3 * SHORT_C + 2 * GAP_C + 3);

    // Second key sampled on the edge where busy falls starts a fresh pattern.
    start_scen("back_to_back");
    push(O_IDLE, 1);
    push(O_KEY, SHORT_C);
    push(O_IDLE, 1);
    push(O_KEY, SHORT_C);
    push(O_IDLE, 3);
    cycle(1'b1, 1'b0, 1'b0);
    idle(SHORT_C);
    cycle(1'b1, 1'b0, 1'b0);
    idle(SHORT_C + 3);

    // Asynchronous reset in the middle of the OK beep.
    start_scen("reset_mid_ok");
    push(O_IDLE, 1);
    push(O_OK, 9);
    cycle(1'b0, 1'b1, 1'b0);
    idle(9);
    #2 rst_n = 1'b0;
    #1;
    push(O_IDLE, 1);
    pop_check();
    @(posedge clk);
    #1;
    push(O_IDLE, 1);
    pop_check();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(O_IDLE, 6);
    push(O_IDLE, 1);
    push(O_KEY, SHORT_C);
    push(O_IDLE, 2);
    idle(6);
    cycle(1'b1, 1'b0, 1'b0);
    idle(SHORT_C + 2);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
